clk_meter: RTL and testbench

Receive-side companion to the divided low-frequency clocks generated in the design (e.g. 1 MHz from 100 MHz). Samples an asynchronous slow clock `in_clk` in the `clk` domain and measures its period and high time in `clk` cycles. Declares lock when the frequency stays within tolerance, and flags loss when edges stop. Used to self-check divider outputs on the board and in simulation.

---
 rtl/clk_meter_pkg.sv | 16 +
 rtl/clk_meter_sync.sv | 51 +++++
 rtl/clk_meter.sv | 123 ++++++++++++
 tb/tb_clk_meter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_meter_pkg.sv
// Shared types and default parameters for the clk_meter slow-clock checker.
package clk_meter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEAS = 2'd1,
        LOST = 2'd2
    } state_t;

    localparam int DEF_CW         = 16;
    localparam int DEF_EXP_PERIOD = 100;
    localparam int DEF_TOL        = 2;
    localparam int DEF_LOCK_CNT   = 4;
    localparam int DEF_TIMEOUT    = 256;

endpackage

// File: rtl/clk_meter_sync.sv
// Synchronizes in_clk into the clk domain and emits registered rise/fall pulses.
// Optional glitch filter on the synchronized level: CLK_METER_GLITCH_FILTER_EN.
module clk_meter_sync (
    input  logic clk,
    input  logic rst,
    input  logic in_clk,
    output logic rise,
    output logic fall
);

    logic r_s1, r_s2, r_s3;
    logic r_rise, r_fall;
    logic w_lvl;

`ifdef CLK_METER_GLITCH_FILTER_EN
    logic r_filt;

    // Level follows only when the two newest samples agree and differ from it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_filt <= 1'b0;
        end else if ((r_s1 == r_s2) && (r_s2 != r_filt)) begin
            r_filt <= r_s2;
        end
    end

    assign w_lvl = r_filt;
`else
    assign w_lvl = r_s2;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_s3   <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_s1   <= in_clk;
            r_s2   <= r_s1;
            r_s3   <= w_lvl;
            r_rise <= w_lvl & ~r_s3;
            r_fall <= ~w_lvl & r_s3;
        end
    end

    assign rise = r_rise;
    assign fall = r_fall;

endmodule

// File: rtl/clk_meter.sv
// Measures period/high time of an asynchronous slow clock, tracks lock and loss.
// Build option: CLK_METER_GLITCH_FILTER_EN (handled inside clk_meter_sync).
module clk_meter
    import clk_meter_pkg::*;
#(
    parameter int CW         = DEF_CW,
    parameter int EXP_PERIOD = DEF_EXP_PERIOD,
    parameter int TOL        = DEF_TOL,
    parameter int LOCK_CNT   = DEF_LOCK_CNT,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_clk,
    output logic [CW-1:0] period_o,
    output logic [CW-1:0] high_o,
    output logic          meas_valid,
    output logic          locked,
    output logic          lost
);

    localparam int CW1 = CW + 1;
    localparam int GW  = $clog2(LOCK_CNT + 1);

    localparam logic [CW-1:0]         TIMEOUT_C = CW'(TIMEOUT);
    localparam logic [GW-1:0]         LOCK_C    = GW'(LOCK_CNT);
    localparam logic signed [CW1-1:0] EXP_S     = CW1'(EXP_PERIOD);
    localparam logic signed [CW1-1:0] TOL_S     = CW1'(TOL);

    logic                  w_rise, w_fall;
    logic [CW-1:0]         r_per_cnt, r_hi_cap;
    logic [CW-1:0]         r_period, r_high;
    logic                  r_valid, r_locked, r_lost;
    logic [GW-1:0]         r_good_cnt, w_good_nxt;
    logic signed [CW1-1:0] w_diff;
    logic                  w_good;
    state_t                r_state;

    clk_meter_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .in_clk (in_clk),
        .rise   (w_rise),
        .fall   (w_fall)
    );

    // Cycles since the last rise; reads the full period on the next rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_per_cnt <= '0;
        end else if (w_rise) begin
            r_per_cnt <= CW'(1);
        end else if (r_per_cnt != TIMEOUT_C) begin
            r_per_cnt <= r_per_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi_cap <= '0;
        end else if (w_fall) begin
            r_hi_cap <= r_per_cnt;
        end
    end

    // One extra bit keeps the signed difference from wrapping.
    assign w_diff     = $signed({1'b0, r_per_cnt}) - EXP_S;
    assign w_good     = (w_diff <= TOL_S) && (w_diff >= -TOL_S);
    assign w_good_nxt = (r_good_cnt == LOCK_C) ? LOCK_C : r_good_cnt + GW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_period   <= '0;
            r_high     <= '0;
            r_valid    <= 1'b0;
            r_locked   <= 1'b0;
            r_lost     <= 1'b0;
            r_good_cnt <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_rise) r_state <= MEAS;
                end
                MEAS: begin
                    if (w_rise) begin
                        r_period <= r_per_cnt;
                        r_high   <= r_hi_cap;
                        r_valid  <= 1'b1;
                        if (w_good) begin
                            r_good_cnt <= w_good_nxt;
                            r_locked   <= (w_good_nxt == LOCK_C);
                        end else begin
                            r_good_cnt <= '0;
                            r_locked   <= 1'b0;
                        end
                    end else if (r_per_cnt == TIMEOUT_C) begin
                        r_state    <= LOST;
                        r_lost     <= 1'b1;
                        r_locked   <= 1'b0;
                        r_good_cnt <= '0;
                    end
                end
                LOST: begin
                    // Re-arm only; the first period after loss is partial.
                    if (w_rise) begin
                        r_state <= MEAS;
                        r_lost  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign period_o   = r_period;
    assign high_o     = r_high;
    assign meas_valid = r_valid;
    assign locked     = r_locked;
    assign lost       = r_lost;

endmodule

// File: tb/tb_clk_meter.sv
// Directed bench for clk_meter with an edge-timestamp reference model.
module tb_clk_meter;

    localparam int CW    = 16;
    localparam int EXP   = 100;
    localparam int TOL   = 2;
    localparam int LOCKN = 4;
    localparam int TMO   = 256;
`ifdef CLK_METER_GLITCH_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_clk;
    logic [CW-1:0] period_o, high_o;
    logic          meas_valid, locked, lost;

    always #5 clk = ~clk;

    clk_meter dut (
        .clk        (clk),
        .rst        (rst),
        .in_clk     (in_clk),
        .period_o   (period_o),
        .high_o     (high_o),
        .meas_valid (meas_valid),
        .locked     (locked),
        .lost       (lost)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: timestamps of edges on the (optionally filtered) sampled
    // level, seen 3 edges later; period/high are differences of timestamps.
    int            k = 0;
    bit            lq[5];
    bit            vprev = 1'b0, fl = 1'b0;
    int            mode = 0;            // 0 idle, 1 measuring, 2 lost
    int            last_rise = 0, hi = 0, good = 0;
    logic          m_valid = 1'b0, m_locked = 1'b0, m_lost = 1'b0;
    logic [CW-1:0] m_period = '0, m_high = '0;

    always @(posedge clk) begin : model
        bit v, lv, r_e, f_e;
        int dt;
        k++;
        if (rst) begin
            for (int i = 0; i < 5; i++) lq[i] = 1'b0;
            vprev = 1'b0; fl = 1'b0; mode = 0; hi = 0; good = 0;
            last_rise = k + 1;
            m_valid = 1'b0; m_locked = 1'b0; m_lost = 1'b0;
            m_period = '0; m_high = '0;
        end else begin
            v = in_clk;
            if (FILT) begin
                if (v == vprev) fl = v;
                lv = fl;
            end else begin
                lv = v;
            end
            vprev = v;
            for (int i = 4; i > 0; i--) lq[i] = lq[i-1];
            lq[0] = lv;
            r_e = lq[3] && !lq[4];
            f_e = !lq[3] && lq[4];
            dt = k - last_rise;
            if (dt > TMO) dt = TMO;
            m_valid = 1'b0;
            if (r_e) begin
                if (mode == 1) begin
                    m_valid  = 1'b1;
                    m_period = CW'(dt);
                    m_high   = CW'(hi);
                    if (dt - EXP <= TOL && EXP - dt <= TOL) begin
                        if (good < LOCKN) good++;
                        m_locked = (good == LOCKN);
                    end else begin
                        good = 0; m_locked = 1'b0;
                    end
                end
                if (mode == 2) m_lost = 1'b0;
                mode = 1;
                last_rise = k;
            end else begin
                if (f_e) hi = dt;
                if (mode == 1 && dt >= TMO) begin
                    mode = 2; m_lost = 1'b1; m_locked = 1'b0; good = 0;
                end
            end
        end
    end

    int vq_per[$];
    int vq_lk[$];

    always @(negedge clk) begin : compare
        logic [2*CW+2:0] a, e;
        a = {meas_valid, locked, lost, period_o, high_o};
        e = {m_valid, m_locked, m_lost, m_period, m_high};
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL cycle_cmp t=%0t dut v=%b lk=%b lost=%b per=%0d hi=%0d want v=%b lk=%b lost=%b per=%0d hi=%0d",
                     $time, meas_valid, locked, lost, period_o, high_o,
                     m_valid, m_locked, m_lost, m_period, m_high);
        end
        if (meas_valid === 1'b1) begin
            vq_per.push_back(int'(period_o));
            vq_lk.push_back(int'(locked));
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        in_clk = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic per(input int p, input int h);
        drive(1'b1, h);
        drive(1'b0, p - h);
    endtask

    function automatic int vper(input int i);
        return (i < vq_per.size()) ? vq_per[i] : -1;
    endfunction

    function automatic int vlk(input int i);
        return (i < vq_lk.size()) ? vq_lk[i] : -1;
    endfunction

    initial begin
        int n0, first_lock;
        rst = 1'b1;
        in_clk = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out", int'({meas_valid, locked, lost, period_o, high_o}), 0);
        rst = 1'b0;
        drive(1'b0, 10);

        // 1: nominal 100/50, first rise only arms
        repeat (6) per(100, 50);
        #1;
        chk("t1_nvalid", vq_per.size(), 5);
        chk("t1_period", int'(period_o), 100);
        chk("t1_high", int'(high_o), 50);
        chk("t1_locked", int'(locked), 1);
        first_lock = -1;
        for (int i = vq_lk.size() - 1; i >= 0; i--) if (vq_lk[i] == 1) first_lock = i;
        chk("t1_lock_idx", first_lock, 3);

        // 2: one bad period, then relock on 101s
        per(105, 50);
        repeat (4) per(101, 50);
        per(100, 50);
        #1;
        chk("t2_bad_per", vper(6), 105);
        chk("t2_bad_lk", vlk(6), 0);
        chk("t2_3rd_lk", vlk(9), 0);
        chk("t2_relock", vlk(10), 1);
        chk("t2_per101", vper(10), 101);

        // 3: stop, lose, restart
        drive(1'b0, 300);
        #1;
        chk("t3_lost", int'(lost), 1);
        chk("t3_unlock", int'(locked), 0);
        chk("t3_hold", int'(period_o), 101);
        n0 = vq_per.size();
        per(100, 50);
        #1;
        chk("t3_rearm_nv", vq_per.size() - n0, 0);
        chk("t3_cleared", int'(lost), 0);
        per(100, 50);
        #1;
        chk("t3_nv", vq_per.size() - n0, 1);
        chk("t3_period", int'(period_o), 100);

        // 4: reset during the low phase while locked
        repeat (5) per(100, 50);
        #1;
        chk("t4_pre_lock", int'(locked), 1);
        drive(1'b1, 50);
        drive(1'b0, 25);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t4_rst_out", int'({meas_valid, locked, lost, period_o, high_o}), 0);
        drive(1'b0, 24);
        n0 = vq_per.size();
        per(100, 50);
        per(100, 50);
        #1;
        chk("t4_nv", vq_per.size() - n0, 1);
        chk("t4_period", int'(period_o), 100);
        chk("t4_lock", int'(locked), 0);

        // 5: one-cycle glitch in the low phase
        n0 = vq_per.size();
        drive(1'b1, 50);
        drive(1'b0, 20);
        drive(1'b1, 1);
        drive(1'b0, 29);
        drive(1'b1, 50);
        drive(1'b0, 50);
        #1;
        if (FILT) begin
            chk("t5_nv", vq_per.size() - n0, 2);
            chk("t5_period", int'(period_o), 100);
            chk("t5_high", int'(high_o), 50);
        end else begin
            chk("t5_nv", vq_per.size() - n0, 3);
            chk("t5_spur", vper(n0 + 1), 70);
            chk("t5_period", int'(period_o), 30);
            chk("t5_high", int'(high_o), 1);
        end

        // 6: period exactly at the timeout boundary
        drive(1'b1, 50);
        drive(1'b0, 206);
        drive(1'b1, 50);
        drive(1'b0, 50);
        #1;
        chk("t6_period", int'(period_o), 256);
        chk("t6_high", int'(high_o), 50);
        chk("t6_lost", int'(lost), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
